// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and decode helpers for the MIPS memory stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LH   = 4'd2,
      OP_LW   = 4'd3,
      OP_LBU  = 4'd4,
      OP_LHU  = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_e;

   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_signed_load(input logic [3:0] op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

   // Codes outside the defined set fall through to word size; they are
   // never treated as memory ops, so the size is don't-care for them.
   function automatic mem_size_e op_size(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         default:              return SZ_WORD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Store lane replication / byte enables and load lane
//                extraction with sign or zero extension (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = $clog2(DATA_W / 8)
) (
   input  mem_size_e               st_size,
   input  logic [LANE_W-1:0]       st_lane,
   input  logic [DATA_W-1:0]       st_data,
   output logic [DATA_W/8-1:0]     st_be,
   output logic [DATA_W-1:0]       st_wdata,
   input  mem_size_e               ld_size,
   input  logic [LANE_W-1:0]       ld_lane,
   input  logic                    ld_signed,
   input  logic [DATA_W-1:0]       rdata,
   output logic [DATA_W-1:0]       ld_data
);

   localparam int NB = DATA_W / 8;
   localparam logic [NB-1:0] c_be_byte = NB'(1);
   localparam logic [NB-1:0] c_be_half = NB'(3);

   logic [DATA_W-1:0] shifted;

   always_comb begin
      st_be    = '1;
      st_wdata = st_data;
      case (st_size)
         SZ_BYTE: begin
            st_be    = c_be_byte << st_lane;
            st_wdata = {NB{st_data[7:0]}};
         end
         SZ_HALF: begin
            st_be    = c_be_half << st_lane;
            st_wdata = {(NB / 2){st_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Bring the addressed lane down to bit 0 before extending it.
   always_comb begin
      shifted = rdata >> {ld_lane, 3'b000};
      ld_data = rdata;
      case (ld_size)
         SZ_BYTE: ld_data = {{(DATA_W - 8){ld_signed & shifted[7]}}, shifted[7:0]};
         SZ_HALF: ld_data = {{(DATA_W - 16){ld_signed & shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Registered MIPS memory-access stage with req/ack bus,
//                IO window decode and lane-aligned loads/stores.
//                Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
   import mem_pkg::*;
#(
   parameter int          DATA_W  = 32,
   parameter int          ADDR_W  = 32,
   parameter int          REG_AW  = 5,
   parameter logic [31:0] IO_MASK = 32'hFFFF_F000,
   parameter logic [31:0] IO_BASE = 32'hFFFF_F000,
   parameter int          TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid,
   input  logic [3:0]          ex_mem_op,
   input  logic [REG_AW-1:0]   ex_waddr,
   input  logic                ex_wreg,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic [DATA_W-1:0]   ex_store_data,
   output logic                stall,
   output logic                m_req,
   output logic                m_we,
   output logic                m_io,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W/8-1:0] m_be,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ack,
   output logic [REG_AW-1:0]   wb_waddr,
   output logic                wb_wreg,
   output logic [DATA_W-1:0]   wb_wdata,
   output logic                misalign,
   output logic                bus_err
);

   localparam int NB     = DATA_W / 8;
   localparam int LANE_W = $clog2(NB);
   localparam logic [ADDR_W-1:0] c_io_mask   = ADDR_W'(IO_MASK);
   localparam logic [ADDR_W-1:0] c_io_base   = ADDR_W'(IO_BASE);
   localparam logic [ADDR_W-1:0] c_lane_mask = ADDR_W'(NB - 1);

   mem_state_e          state_q, state_d;
   logic                m_req_q, m_req_d;
   logic                m_we_q, m_we_d;
   logic                m_io_q, m_io_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [NB-1:0]       m_be_q, m_be_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic [REG_AW-1:0]   wb_waddr_q, wb_waddr_d;
   logic                wb_wreg_q, wb_wreg_d;
   logic [DATA_W-1:0]   wb_wdata_q, wb_wdata_d;
   logic                misalign_q, misalign_d;
   logic                bus_err_q, bus_err_d;
   mem_size_e           size_q, size_d;
   logic                signed_q, signed_d;
   logic                load_q, load_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [REG_AW-1:0]   dst_q, dst_d;

   logic [ADDR_W-1:0]   addr;
   logic [LANE_W-1:0]   lane;
   mem_size_e           ex_size;
   logic                ex_mem;
   logic                aligned;
   logic                io_hit;
   logic [NB-1:0]       st_be;
   logic [DATA_W-1:0]   st_wdata;
   logic [DATA_W-1:0]   ld_data;

`ifdef MEM_TIMEOUT_EN
   localparam int c_tmo_w = (TIMEOUT < 256) ? 8 : 16;
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
   logic [c_tmo_w-1:0] tmo_q, tmo_d;
`endif

   assign addr    = ADDR_W'(ex_wdata);
   assign lane    = addr[LANE_W-1:0];
   assign ex_size = op_size(ex_mem_op);
   assign ex_mem  = is_load(ex_mem_op) || is_store(ex_mem_op);
   assign io_hit  = (addr & c_io_mask) == c_io_base;

   always_comb begin
      aligned = 1'b1;
      case (ex_size)
         SZ_HALF: aligned = ~addr[0];
         SZ_WORD: aligned = (lane == '0);
         default: ;
      endcase
   end

   mem_lane_align #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_lane_align (
      .st_size   (ex_size),
      .st_lane   (lane),
      .st_data   (ex_store_data),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_size   (size_q),
      .ld_lane   (lane_q),
      .ld_signed (signed_q),
      .rdata     (m_rdata),
      .ld_data   (ld_data)
   );

   always_comb begin
      state_d    = state_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_io_d     = m_io_q;
      m_addr_d   = m_addr_q;
      m_be_d     = m_be_q;
      m_wdata_d  = m_wdata_q;
      wb_waddr_d = wb_waddr_q;
      wb_wreg_d  = 1'b0;
      wb_wdata_d = wb_wdata_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      size_d     = size_q;
      signed_d   = signed_q;
      load_d     = load_q;
      lane_d     = lane_q;
      dst_d      = dst_q;
`ifdef MEM_TIMEOUT_EN
      tmo_d      = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               if (!ex_mem) begin
                  wb_waddr_d = ex_waddr;
                  wb_wreg_d  = ex_wreg;
                  wb_wdata_d = ex_wdata;
               end else if (!aligned) begin
                  misalign_d = 1'b1;
               end else begin
                  state_d   = ST_BUSY;
                  m_req_d   = 1'b1;
                  m_we_d    = is_store(ex_mem_op);
                  m_io_d    = io_hit;
                  m_addr_d  = addr & ~c_lane_mask;
                  m_be_d    = st_be;
                  m_wdata_d = is_store(ex_mem_op) ? st_wdata : '0;
                  size_d    = ex_size;
                  signed_d  = is_signed_load(ex_mem_op);
                  load_d    = is_load(ex_mem_op);
                  lane_d    = lane;
                  dst_d     = ex_waddr;
               end
            end
         end
         ST_BUSY: begin
`ifdef MEM_TIMEOUT_EN
            tmo_d = tmo_q + 1'b1;
`endif
            if (m_ack) begin
               state_d = ST_IDLE;
               m_req_d = 1'b0;
               m_we_d  = 1'b0;
               m_be_d  = '0;
               if (load_q) begin
                  wb_wreg_d  = 1'b1;
                  wb_waddr_d = dst_q;
                  wb_wdata_d = ld_data;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo_q == c_tmo_last) begin
               state_d   = ST_IDLE;
               m_req_d   = 1'b0;
               m_we_d    = 1'b0;
               m_be_d    = '0;
               bus_err_d = 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_io_q     <= 1'b0;
         m_addr_q   <= '0;
         m_be_q     <= '0;
         m_wdata_q  <= '0;
         wb_waddr_q <= '0;
         wb_wreg_q  <= 1'b0;
         wb_wdata_q <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         size_q     <= SZ_BYTE;
         signed_q   <= 1'b0;
         load_q     <= 1'b0;
         lane_q     <= '0;
         dst_q      <= '0;
      end else begin
         state_q    <= state_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_io_q     <= m_io_d;
         m_addr_q   <= m_addr_d;
         m_be_q     <= m_be_d;
         m_wdata_q  <= m_wdata_d;
         wb_waddr_q <= wb_waddr_d;
         wb_wreg_q  <= wb_wreg_d;
         wb_wdata_q <= wb_wdata_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         load_q     <= load_d;
         lane_q     <= lane_d;
         dst_q      <= dst_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`endif

   assign stall    = (state_q == ST_BUSY);
   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_io     = m_io_q;
   assign m_addr   = m_addr_q;
   assign m_be     = m_be_q;
   assign m_wdata  = m_wdata_q;
   assign wb_waddr = wb_waddr_q;
   assign wb_wreg  = wb_wreg_q;
   assign wb_wdata = wb_wdata_q;
   assign misalign = misalign_q;
   assign bus_err  = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage with a
//                writeback scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic [3:0]  ex_mem_op = 4'd0;
   logic [4:0]  ex_waddr = 5'd0;
   logic        ex_wreg = 1'b0;
   logic [31:0] ex_wdata = 32'd0;
   logic [31:0] ex_store_data = 32'd0;
   logic        stall, m_req, m_we, m_io;
   logic [31:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = 32'd0;
   logic        m_ack = 1'b0;
   logic [4:0]  wb_waddr;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        misalign, bus_err;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } wb_exp_t;
   wb_exp_t exp_q[$];

   mem_stage #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .REG_AW  (5),
      .IO_MASK (32'hFFFF_F000),
      .IO_BASE (32'hFFFF_F000),
      .TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_mem_op     (ex_mem_op),
      .ex_waddr      (ex_waddr),
      .ex_wreg       (ex_wreg),
      .ex_wdata      (ex_wdata),
      .ex_store_data (ex_store_data),
      .stall         (stall),
      .m_req         (m_req),
      .m_we          (m_we),
      .m_io          (m_io),
      .m_addr        (m_addr),
      .m_be          (m_be),
      .m_wdata       (m_wdata),
      .m_rdata       (m_rdata),
      .m_ack         (m_ack),
      .wb_waddr      (wb_waddr),
      .wb_wreg       (wb_wreg),
      .wb_wdata      (wb_wdata),
      .misalign      (misalign),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and retire any writeback against the scoreboard.
   task automatic tick();
      wb_exp_t e;
      @(negedge clk);
      if (wb_wreg !== 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("wb_spurious", 64'(wb_wreg), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_waddr", 64'(wb_waddr), 64'(e.waddr));
            chk("wb_wdata", 64'(wb_wdata), 64'(e.wdata));
         end
      end
   endtask

   task automatic push(input logic [4:0] wa, input logic [31:0] wd);
      wb_exp_t e;
      e.waddr = wa;
      e.wdata = wd;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] wa);
      ex_valid      = 1'b1;
      ex_mem_op     = op;
      ex_wdata      = a;
      ex_store_data = sd;
      ex_waddr      = wa;
      ex_wreg       = 1'b1;
      tick();
      ex_valid      = 1'b0;
      ex_mem_op     = 4'd0;
   endtask

   task automatic complete(input int nwait, input logic [31:0] rd,
                           output int scnt, output int rcnt);
      scnt = int'(stall);
      rcnt = int'(m_req);
      for (int i = 0; i < nwait; i++) begin
         tick();
         scnt += int'(stall);
         rcnt += int'(m_req);
      end
      m_ack   = 1'b1;
      m_rdata = rd;
      tick();
      m_ack   = 1'b0;
      m_rdata = 32'd0;
   endtask

   task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [4:0] wa, input int nwait,
                          input logic [31:0] rd, input logic [31:0] exp);
      int scnt, rcnt;
      issue(op, a, 32'd0, wa);
      push(wa, exp);
      complete(nwait, rd, scnt, rcnt);
      chk({tag, "_stall_cycles"}, 64'(scnt), 64'(nwait + 1));
      chk({tag, "_req_cycles"}, 64'(rcnt), 64'(nwait + 1));
      chk({tag, "_stall_after"}, 64'(stall), 64'd0);
   endtask

   initial begin
      int scnt, rcnt;

      // Reset state
      tick();
      tick();
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_m_req", 64'(m_req), 64'd0);
      chk("rst_m_we", 64'(m_we), 64'd0);
      chk("rst_m_io", 64'(m_io), 64'd0);
      chk("rst_m_be", 64'(m_be), 64'd0);
      chk("rst_m_addr", 64'(m_addr), 64'd0);
      chk("rst_m_wdata", 64'(m_wdata), 64'd0);
      chk("rst_wb", {31'd0, wb_wreg, 27'd0, wb_waddr}, 64'd0);
      chk("rst_wb_wdata", 64'(wb_wdata), 64'd0);
      chk("rst_misalign", 64'(misalign), 64'd0);
      chk("rst_bus_err", 64'(bus_err), 64'd0);
      rst = 1'b0;
      tick();

      // Non-memory op: ADD 0x1234 -> r3, latency 1, no stall
      push(5'd3, 32'h0000_1234);
      issue(OP_NONE, 32'h0000_1234, 32'd0, 5'd3);
      chk("add_wreg", 64'(wb_wreg), 64'd1);
      chk("add_stall", 64'(stall), 64'd0);
      tick();
      chk("add_wreg_not_held", 64'(wb_wreg), 64'd0);

      // Back-to-back non-memory ops, plus one with wreg cleared
      push(5'd4, 32'hDEAD_0001);
      issue(OP_NONE, 32'hDEAD_0001, 32'd0, 5'd4);
      push(5'd5, 32'hDEAD_0002);
      issue(OP_NONE, 32'hDEAD_0002, 32'd0, 5'd5);
      chk("b2b_wreg", 64'(wb_wreg), 64'd1);
      ex_valid = 1'b1; ex_mem_op = OP_NONE; ex_wreg = 1'b0; ex_wdata = 32'h55;
      tick();
      ex_valid = 1'b0;
      chk("nowreg_wreg", 64'(wb_wreg), 64'd0);

      // Byte loads, 3 wait cycles, sign vs zero extension
      do_load("lb", OP_LB, 32'h0000_0103, 5'd6, 3, 32'h8000_0000, 32'hFFFF_FF80);
      do_load("lbu", OP_LBU, 32'h0000_0103, 5'd7, 3, 32'h8000_0000, 32'h0000_0080);

      // Half loads on both lanes
      do_load("lh", OP_LH, 32'h0000_0106, 5'd8, 1, 32'h8001_0000, 32'hFFFF_8001);
      do_load("lhu", OP_LHU, 32'h0000_0100, 5'd9, 0, 32'h1234_9ABC, 32'h0000_9ABC);

      // IO window decode, zero-wait (latency 2)
      issue(OP_LW, 32'hFFFF_F004, 32'd0, 5'd10);
      chk("lw_io_m_io", 64'(m_io), 64'd1);
      chk("lw_io_m_req", 64'(m_req), 64'd1);
      chk("lw_io_m_addr", 64'(m_addr), 64'hFFFF_F004);
      push(5'd10, 32'hCAFE_F00D);
      complete(0, 32'hCAFE_F00D, scnt, rcnt);
      chk("lw_io_stall_cycles", 64'(scnt), 64'd1);
      chk("lw_io_wreg", 64'(wb_wreg), 64'd1);

      issue(OP_LW, 32'h0000_1004, 32'd0, 5'd11);
      chk("lw_ram_m_io", 64'(m_io), 64'd0);
      chk("lw_ram_m_we", 64'(m_we), 64'd0);
      push(5'd11, 32'h1234_5678);
      complete(2, 32'h1234_5678, scnt, rcnt);

      // Stores: byte enables, replication, no writeback
      issue(OP_SH, 32'h0000_0202, 32'h0000_ABCD, 5'd12);
      chk("sh_m_be", 64'(m_be), 64'hC);
      chk("sh_m_wdata", 64'(m_wdata), 64'hABCD_ABCD);
      chk("sh_m_addr", 64'(m_addr), 64'h200);
      chk("sh_m_we", 64'(m_we), 64'd1);
      complete(1, 32'd0, scnt, rcnt);
      chk("sh_wreg", 64'(wb_wreg), 64'd0);

      issue(OP_SB, 32'h0000_0101, 32'h1234_565A, 5'd13);
      chk("sb_m_be", 64'(m_be), 64'h2);
      chk("sb_m_wdata", 64'(m_wdata), 64'h5A5A_5A5A);
      complete(0, 32'd0, scnt, rcnt);

      issue(OP_SW, 32'h0000_0300, 32'hDEAD_BEEF, 5'd14);
      chk("sw_m_be", 64'(m_be), 64'hF);
      chk("sw_m_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
      chk("sw_m_addr", 64'(m_addr), 64'h300);
      complete(0, 32'd0, scnt, rcnt);

      // Misaligned word and half accesses
      issue(OP_LW, 32'h0000_0102, 32'd0, 5'd15);
      chk("misal_lw_pulse", 64'(misalign), 64'd1);
      chk("misal_lw_req", 64'(m_req), 64'd0);
      chk("misal_lw_stall", 64'(stall), 64'd0);
      chk("misal_lw_wreg", 64'(wb_wreg), 64'd0);
      tick();
      chk("misal_lw_pulse_end", 64'(misalign), 64'd0);
      issue(OP_LH, 32'h0000_0101, 32'd0, 5'd16);
      chk("misal_lh_pulse", 64'(misalign), 64'd1);
      chk("misal_lh_req", 64'(m_req), 64'd0);

      // Ack while idle is ignored
      m_ack = 1'b1;
      m_rdata = 32'hFFFF_FFFF;
      tick();
      tick();
      m_ack = 1'b0;
      m_rdata = 32'd0;
      chk("idle_ack_stall", 64'(stall), 64'd0);
      chk("idle_ack_req", 64'(m_req), 64'd0);

      // Reset while busy drops the transfer
      issue(OP_LW, 32'h0000_0400, 32'd0, 5'd17);
      tick();
      chk("rstbusy_stall_before", 64'(stall), 64'd1);
      rst = 1'b1;
      tick();
      chk("rstbusy_req", 64'(m_req), 64'd0);
      chk("rstbusy_stall", 64'(stall), 64'd0);
      chk("rstbusy_wreg", 64'(wb_wreg), 64'd0);
      rst = 1'b0;
      tick();
      chk("rstbusy_stall_after", 64'(stall), 64'd0);

`ifdef MEM_TIMEOUT_EN
      begin
         int cyc = 0;
         issue(OP_LW, 32'h0000_0500, 32'd0, 5'd18);
         for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus_err === 1'b1) begin
               cyc = i;
               break;
            end
         end
         chk("tmo_bus_err_cycle", 64'(cyc), 64'd4);
         chk("tmo_req", 64'(m_req), 64'd0);
         chk("tmo_stall", 64'(stall), 64'd0);
         tick();
         chk("tmo_bus_err_end", 64'(bus_err), 64'd0);
      end
`else
      chk("bus_err_tied", 64'(bus_err), 64'd0);
`endif

      tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Parametrised, registered memory-access stage for the MIPS pipeline, placed between EX and the register-file write port. It generalises the combinational lw/sw path: full/half/byte loads with sign or zero extension, byte-enabled stores, a configurable IO window, and a req/ack bus handshake that stalls the pipeline for multi-cycle memory. Results reach the register file one cycle after the access completes.

## Interface
- `DATA_W`, 32: data width; multiple of 8, at least 32.
- `ADDR_W`, 32: address width.
- `REG_AW`, 5: register-address width.
- `IO_MASK`, 32'hFFFF_F000: address mask for IO decode; truncated to `ADDR_W`.
- `IO_BASE`, 32'hFFFF_F000: an address is IO when `(addr & IO_MASK) == IO_BASE`.
- `TIMEOUT`, 255: bus watchdog limit in cycles; used only with `MEM_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `ex_valid`  in  1  EX presents an instruction.
- `ex_mem_op`  in  4  memory-op code; see the package.
- `ex_waddr`  in  REG_AW  destination register.
- `ex_wreg`  in  1  register-write enable.
- `ex_wdata`  in  DATA_W  ALU result; this is the address for memory ops.
- `ex_store_data`  in  DATA_W  rt value for stores.
- `stall`  out  1  EX must hold its outputs; `ex_valid` is ignored while high.
- `m_req`  out  1  bus request.
- `m_we`  out  1  1 = write.
- `m_io`  out  1  request targets the IO window.
- `m_addr`  out  ADDR_W  word-aligned address (low lane bits zeroed).
- `m_be`  out  DATA_W/8  byte enables.
- `m_wdata`  out  DATA_W  lane-replicated store data.
- `m_rdata`  in  DATA_W  read data; valid when `m_ack` is high.
- `m_ack`  in  1  transfer complete.
- `wb_waddr`  out  REG_AW  register-file write address.
- `wb_wreg`  out  1  register-file write enable; one-cycle pulse per instruction.
- `wb_wdata`  out  DATA_W  register-file write data.
- `misalign`  out  1  one-cycle pulse on a misaligned access.
- `bus_err`  out  1  one-cycle pulse on a watchdog abort (only with `MEM_TIMEOUT_EN`).

## Operation
- FSM states are IDLE and BUSY. `stall = (state == BUSY)`.
- IDLE, non-memory op accepted: register `ex_waddr`, `ex_wreg` and `ex_wdata` straight to the `wb_*` outputs.
- IDLE, memory op accepted: check alignment.
  - Half accesses need `addr[0] == 0`.
  - Word accesses need all lane bits 0; lane bits are `addr[$clog2(DATA_W/8)-1:0]`.
  - Aligned: latch op, lane, IO decode and destination; drive the bus outputs; go to BUSY.
  - Misaligned: no bus request, `wb_wreg = 0`, pulse `misalign` next cycle, stay in IDLE.
- BUSY: hold `m_req` and every bus output stable until `m_ack`. On ack, return to IDLE.
  - Load: select the lane from `m_rdata`, sign- or zero-extend it to DATA_W, and write `wb_wreg = 1` with that data.
  - Store: `wb_wreg = 0`.
- Store byte enables: SB sets the single lane bit. SH sets two adjacent lane bits. SW sets all bits. `m_wdata` replicates the low byte or half of `ex_store_data` across every lane.
- `m_io` is registered with the request. IO and RAM share one handshake.
- `wb_wreg` is 0 for any cycle that does not complete an instruction. It is never held.

## Timing
- Reset values: state IDLE; `stall`, `m_req`, `m_we`, `m_io`, `m_be`, `m_addr`, `m_wdata`, `wb_wreg`, `wb_waddr`, `wb_wdata`, `misalign`, `bus_err` all 0.
- Non-memory op: latency 1. Accepted at cycle N, `wb_*` valid at N+1.
- Memory op accepted at cycle N:
  - `m_req` is high from N+1.
  - If `m_ack` arrives at cycle A (A ≥ N+1), `wb_*` are valid at A+1 and `stall` is low from A+1.
  - Zero-wait memory (ack at N+1) gives latency 2.
- `stall` is high for cycles N+1 through A. A new instruction can be accepted at A+1.
- `m_ack` outside BUSY is ignored.
- `rst` during BUSY: next cycle returns to IDLE with `m_req = 0` and no writeback. The abandoned transfer is dropped and the slave must tolerate this.

## Configuration
- `MEM_TIMEOUT_EN` defined: an 8..16-bit cycle counter, wide enough for `TIMEOUT`, runs in BUSY. If it reaches `TIMEOUT` without `m_ack`:
  - drop `m_req`;
  - pulse `bus_err`;
  - suppress writeback;
  - return to IDLE.
- `MEM_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely and `bus_err` is tied to 0.

## Structure
- Shared package `mem_pkg`:
  - `mem_op` encoding: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8;
  - FSM state typedef;
  - helper functions `is_load`, `is_store`, `op_size`.
- One sub-module, `mem_lane_align`:
  - combinational store lane replication and byte-enable generation;
  - load lane extraction and extension.

## Test plan
- ADD result 0x1234 to r3 -> `wb_wreg` = 1, `wb_waddr` = 3, `wb_wdata` = 0x1234 one cycle later; `stall` never rises.
- LB at 0x103 with `m_rdata` 0x80_00_00_00 and ack after 3 wait cycles -> `stall` high for 4 cycles; `wb_wdata` = 0xFFFF_FF80. Same case with LBU -> 0x0000_0080.
- SH at 0x202, data 0xABCD -> `m_be` = 4'b1100, `m_wdata` = 0xABCD_ABCD, `m_addr` = 0x200, `m_we` = 1; `wb_wreg` stays 0.
- LW at 0xFFFF_F004 -> `m_io` = 1, `m_req` = 1. LW at 0x0000_1004 -> `m_io` = 0.
- LW at 0x102 -> `misalign` pulses; `m_req` and `wb_wreg` stay 0.
- `rst` asserted in BUSY -> next cycle `m_req` = 0, `stall` = 0, no writeback. With `MEM_TIMEOUT_EN` and `TIMEOUT` = 4 and no ack -> `bus_err` pulses after 4 cycles.
